// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: byte type, FSM state encoding, defaults.
package UartPack;

    typedef logic [7:0] uart_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } UartArbState;

    localparam uart_t EOL_DEFAULT = 8'h0A;

    // Successor of idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above i_ptr, wrapping modulo N.
// Purely combinational; no state, no backpressure.
module rr_picker
    import UartPack::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_winner,
    output logic          o_any
);

    int unsigned w_idx;
    logic        w_found;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = 32'(i_ptr) + 32'(i);
            if (w_idx >= 32'(N)) begin
                w_idx = w_idx - 32'(N);
            end
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                w_found  = 1'b1;
                o_winner = w_idx[IW-1:0];
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a UART TX FIFO; a grant lasts until EOL_BYTE or MAX_BURST bytes.
// Latency: 1 cycle to grant, then zero-latency pass-through; holder sees out_ready directly.
// Optional idle-holder timeout under UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import UartPack::*;
#(
    parameter int    NUM_REQ        = 4,
    parameter int    MAX_BURST      = 64,
    parameter uart_t EOL_BYTE       = EOL_DEFAULT,
    parameter int    TIMEOUT_CYCLES = 1024
) (
    input  logic                       core_clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  uart_t [NUM_REQ-1:0]        req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output uart_t                      out_data,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    UartArbState   r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant;
    logic [CW-1:0] r_byte_cnt;
    logic          r_busy;

    logic [IW-1:0] w_winner;
    logic          w_any;
    logic          w_locked;
    logic          w_hold_vld;
    uart_t         w_hold_dat;
    logic          w_fire;
    logic          w_eol;
    logic          w_cap;
    logic          w_release;
    logic          w_timeout;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_locked   = (r_state == LOCKED);
    assign w_hold_vld = req_valid[r_grant];
    assign w_hold_dat = req_data[r_grant];
    assign w_fire     = w_locked && w_hold_vld && out_ready;
    assign w_eol      = (w_hold_dat == EOL_BYTE);
    assign w_cap      = (r_byte_cnt == CW'(MAX_BURST - 1));
    assign w_release  = (w_fire && (w_eol || w_cap)) || w_timeout;

    // Holder is wired straight to the FIFO; nothing is buffered here.
    assign out_valid = w_locked && w_hold_vld;
    assign out_data  = w_locked ? w_hold_dat : 8'h00;
    assign grant_id  = r_grant;
    assign busy      = r_busy;

    always_comb begin
        req_ready = '0;
        if (w_locked) begin
            req_ready[r_grant] = out_ready;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_idle_cnt;

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_locked || w_hold_vld || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end

    assign w_timeout = w_locked && !w_hold_vld && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // No idle release in this build; the comparison is constant false.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_byte_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= LOCKED;
                        r_grant    <= w_winner;
                        r_byte_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_release) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_byte_cnt <= '0;
                        r_rr_ptr   <= IW'(rr_next(32'(r_grant), NUM_REQ));
                    end else if (w_fire) begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus multi-cycle corner sequences.
module tb_uart_tx_arbiter;
    import UartPack::*;

    logic          core_clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    uart_t [3:0]   req_data;
    logic [3:0]    req_ready;
    logic          out_valid;
    uart_t         out_data;
    logic          out_ready;
    logic [1:0]    grant_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        ordy;
        logic        eov;
        uart_t       eod;
        logic [3:0]  erdy;
        logic [1:0]  egid;
        logic        ebusy;
    } vec_t;

    vec_t tv [0:21];

    always #5 core_clk = ~core_clk;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .MAX_BURST      (4),
        .EOL_BYTE       (8'h0A),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .core_clk  (core_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic eov, input uart_t eod,
                           input logic [3:0] erdy, input logic [1:0] egid, input logic ebusy);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, " out_data"},  32'(out_data),  32'(eod));
        chk({tag, " req_ready"}, 32'(req_ready), 32'(erdy));
        chk({tag, " grant_id"},  32'(grant_id),  32'(egid));
        chk({tag, " busy"},      32'(busy),      32'(ebusy));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic r);
        @(negedge core_clk);
        req_valid = v;
        req_data  = d;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge core_clk);
        req_valid = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(negedge core_clk);
        rst = 1'b0;
    endtask

    initial begin
        // vld, dat {d3,d2,d1,d0}, out_ready | out_valid, out_data, req_ready, grant_id, busy
        tv[0]  = '{4'b0001, 32'h00000068, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tv[1]  = '{4'b0001, 32'h00000068, 1'b1, 1'b1, 8'h68, 4'b0001, 2'd0, 1'b1};
        tv[2]  = '{4'b0001, 32'h00000069, 1'b1, 1'b1, 8'h69, 4'b0001, 2'd0, 1'b1};
        tv[3]  = '{4'b0001, 32'h0000000A, 1'b1, 1'b1, 8'h0A, 4'b0001, 2'd0, 1'b1};
        tv[4]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tv[5]  = '{4'b0011, 32'h00004241, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tv[6]  = '{4'b0011, 32'h00000A41, 1'b1, 1'b1, 8'h0A, 4'b0010, 2'd1, 1'b1};
        tv[7]  = '{4'b0011, 32'h00000A41, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};
        tv[8]  = '{4'b0001, 32'h0000000A, 1'b1, 1'b1, 8'h0A, 4'b0001, 2'd0, 1'b1};
        tv[9]  = '{4'b0100, 32'h00310000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tv[10] = '{4'b0100, 32'h00310000, 1'b1, 1'b1, 8'h31, 4'b0100, 2'd2, 1'b1};
        for (int i = 11; i <= 15; i++) begin
            tv[i] = '{4'b0100, 32'h00320000, 1'b0, 1'b1, 8'h32, 4'b0000, 2'd2, 1'b1};
        end
        tv[16] = '{4'b0100, 32'h00320000, 1'b1, 1'b1, 8'h32, 4'b0100, 2'd2, 1'b1};
        tv[17] = '{4'b1000, 32'h550A0000, 1'b1, 1'b0, 8'h0A, 4'b0100, 2'd2, 1'b1};
        tv[18] = '{4'b1100, 32'h550A0000, 1'b1, 1'b1, 8'h0A, 4'b0100, 2'd2, 1'b1};
        tv[19] = '{4'b1000, 32'h0A0A0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
        tv[20] = '{4'b1000, 32'h0A000000, 1'b1, 1'b1, 8'h0A, 4'b1000, 2'd3, 1'b1};
        tv[21] = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd3, 1'b0};

        // Reset with every requester shouting: nothing may leak out.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h0A0A0A0A;
        out_ready = 1'b1;
        repeat (2) @(negedge core_clk);
        #1;
        chk_out("reset", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        req_valid = '0;
        rst       = 1'b0;

        // Line grant, pointer advance, backpressure, holder dropping valid.
        for (int i = 0; i <= 21; i++) begin
            step(tv[i].vld, tv[i].dat, tv[i].ordy);
            chk_out($sformatf("vec%0d", i), tv[i].eov, tv[i].eod, tv[i].erdy, tv[i].egid, tv[i].ebusy);
        end

        // Rotation: req0 and req2 both valid after reset.
        do_reset();
        step(4'b0101, 32'h00620061, 1'b1);
        chk_out("rot idle", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        step(4'b0101, 32'h00620061, 1'b1);
        chk_out("rot g0", 1'b1, 8'h61, 4'b0001, 2'd0, 1'b1);
        step(4'b0101, 32'h0062000A, 1'b1);
        chk_out("rot g0 eol", 1'b1, 8'h0A, 4'b0001, 2'd0, 1'b1);
        step(4'b0100, 32'h00620000, 1'b1);
        chk_out("rot gap", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        step(4'b0100, 32'h000A0000, 1'b1);
        chk_out("rot g2", 1'b1, 8'h0A, 4'b0100, 2'd2, 1'b1);

        // Burst cap of 4 for req1 with req3 also pending.
        do_reset();
        step(4'b1010, 32'h0A001100, 1'b1);
        chk_out("cap idle", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = 8'h11 + 8'(k);
            step(4'b1010, {8'h0A, 8'h00, b, 8'h00}, 1'b1);
            chk_out($sformatf("cap byte%0d", k), 1'b1, b, 4'b0010, 2'd1, 1'b1);
        end
        step(4'b1010, 32'h0A001500, 1'b1);
        chk("cap release busy", 32'(busy), 32'd0);
        chk("cap release out_valid", 32'(out_valid), 32'd0);
        step(4'b1010, 32'h0A001500, 1'b1);
        chk_out("cap g3", 1'b1, 8'h0A, 4'b1000, 2'd3, 1'b1);
        step(4'b1010, 32'h0A001500, 1'b1);
        chk("cap gap busy", 32'(busy), 32'd0);
        step(4'b1010, 32'h0A001500, 1'b1);
        chk_out("cap regrant g1", 1'b1, 8'h15, 4'b0010, 2'd1, 1'b1);

        // Holder req1 goes quiet for 8 cycles while req3 waits.
        for (int k = 1; k <= 8; k++) begin
            step(4'b1000, 32'h0A001600, 1'b1);
            chk_out($sformatf("quiet%0d", k), 1'b0, 8'h16, 4'b0010, 2'd1, 1'b1);
        end
        step(4'b1000, 32'h0A001600, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        chk_out("timeout release", 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);
        step(4'b1000, 32'h0A001600, 1'b1);
        chk_out("timeout g3", 1'b1, 8'h0A, 4'b1000, 2'd3, 1'b1);
`else
        chk_out("no timeout a", 1'b0, 8'h16, 4'b0010, 2'd1, 1'b1);
        step(4'b1000, 32'h0A001600, 1'b1);
        chk_out("no timeout b", 1'b0, 8'h16, 4'b0010, 2'd1, 1'b1);
`endif

        // Reset mid-burst with a nonzero pointer.
        do_reset();
        step(4'b0001, 32'h0000000A, 1'b1);
        step(4'b0001, 32'h0000000A, 1'b1);
        chk_out("mid g0", 1'b1, 8'h0A, 4'b0001, 2'd0, 1'b1);
        step(4'b0100, 32'h00710000, 1'b1);
        step(4'b0100, 32'h00710000, 1'b1);
        chk_out("mid g2 b1", 1'b1, 8'h71, 4'b0100, 2'd2, 1'b1);
        step(4'b0100, 32'h00720000, 1'b1);
        chk_out("mid g2 b2", 1'b1, 8'h72, 4'b0100, 2'd2, 1'b1);
        step(4'b0100, 32'h00730000, 1'b1);
        chk_out("mid g2 b3", 1'b1, 8'h73, 4'b0100, 2'd2, 1'b1);
        rst = 1'b1;
        #1;
        chk_out("mid async rst", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        req_valid = 4'b0101;
        req_data  = 32'h00730061;
        @(negedge core_clk);
        rst = 1'b0;
        #1;
        chk_out("post rst idle", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        step(4'b0101, 32'h00730061, 1'b1);
        chk_out("post rst g0", 1'b1, 8'h61, 4'b0001, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of byte requesters (at least 2).
REQ-002 The block SHALL have parameter MAX_BURST, default 64, giving the maximum bytes per grant.
REQ-003 The block SHALL have parameter EOL_BYTE, default 8'h0A, giving the line terminator that ends a grant.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the idle-holder release limit; it is used only with the macro in REQ-022.
REQ-005 The block SHALL have port core_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester byte valid.
REQ-008 The block SHALL have port req_data, input, NUM_REQ x 8 bits: per-requester byte.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
REQ-010 The block SHALL have port out_valid, output, 1 bit: byte valid toward the UART transmit FIFO.
REQ-011 The block SHALL have port out_data, output, 8 bits: byte toward the UART transmit FIFO.
REQ-012 The block SHALL have port out_ready, input, 1 bit: UART transmit FIFO ready.
REQ-013 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: the current holder.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a grant is held.

Function
REQ-015 The block SHALL use a two-state FSM, IDLE and LOCKED.
- IDLE: out_valid=0, all req_ready=0, busy=0.
- Transition: if any req_valid is set, register the grant and enter LOCKED on the next edge.
- Arbitration latency: 1 cycle.
REQ-016 The block SHALL arbitrate round-robin.
- Search starts at rr_ptr and goes upward, modulo NUM_REQ.
- The first requester with req_valid set wins.
REQ-017 In LOCKED, the block SHALL pass the holder g straight through with no buffering.
- out_valid = req_valid[g]; out_data = req_data[g]; req_ready[g] = out_ready.
- All other req_ready = 0.
- The fire condition is out_valid & out_ready.
REQ-018 The block SHALL count fires in LOCKED with byte_cnt, width clog2(MAX_BURST+1). byte_cnt clears on entry to LOCKED.
REQ-019 The block SHALL release the grant on a fire whose data equals EOL_BYTE, or on the fire that brings byte_cnt to MAX_BURST, whichever comes first.
- Release: enter IDLE; rr_ptr <= g+1 modulo NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-020 The block SHALL hold the grant while the holder drops req_valid or out_ready is low; no other requester is served.
REQ-021 On simultaneous release and pending requests, the block SHALL spend exactly one IDLE cycle and then grant the next requester per REQ-016.

Configuration
REQ-022 Macro UART_ARB_TIMEOUT_EN.
- Defined: in LOCKED, an idle counter increments each cycle with req_valid[g]=0 and clears on any cycle with req_valid[g]=1. On reaching TIMEOUT_CYCLES it releases the grant as in REQ-019.
- Undefined: the counter is absent and the grant is held indefinitely per REQ-020.

Reset
REQ-023 While rst=1, the block SHALL force asynchronously: state=IDLE, rr_ptr=0, byte_cnt=0, idle counter=0, grant_id=0, busy=0, out_valid=0, req_ready=0.
REQ-024 A reset asserted mid-burst SHALL abandon the grant with no partial byte issued; after rst falls, arbitration restarts from requester 0.
REQ-025 out_data SHALL be 8'h00 while in IDLE.

Structure
REQ-026 The default EOL_BYTE constant and a UartArbState enum (IDLE, LOCKED) SHALL live in UartPack, alongside the uart_t byte type used for out_data and req_data.
REQ-027 The round-robin priority picker SHALL be a separate sub-module, rr_picker (inputs req vector and ptr; outputs winner index and any-valid flag).

Verification
REQ-028 The bench SHALL cover these scenarios:
- Line grant: req0 sends "hi\n" (68,69,0A) with out_ready=1 -> three out fires in consecutive cycles; IDLE on the cycle after 0A; rr_ptr=1.
- Rotation: req0 and req2 both valid from reset -> req0 is granted first; after its 0A, one IDLE cycle, then grant_id=2.
- Burst cap: MAX_BURST=4, req1 streams 10 bytes with no 0A -> release after the 4th fire; req1 is re-granted only after the other valid requesters are served.
- Backpressure: out_ready=0 for 5 cycles mid-line -> no fires, grant_id stable, req_ready[g]=0; resumes when out_ready=1.
- Timeout (macro defined, TIMEOUT_CYCLES=8): holder drops valid for 8 cycles -> busy falls; pending req3 is granted 1 cycle later. Macro undefined: busy stays 1.
- Reset mid-burst: rst pulse after 2 bytes -> out_valid=0 immediately; after rst falls, grant goes to the lowest-index valid requester.
